// File: rtl/dqpsk_diff_encoder_if.sv
// Dibit-in / constellation-out bundle between the dibit splitter, the
// differential encoder and the pulse-shaping stage.
interface dqpsk_diff_encoder_if #(
  parameter int W = 8
);
  logic                in_valid;
  logic                i_bit;
  logic                q_bit;
  logic                sym_valid;
  logic [1:0]          phase;
  logic signed [W-1:0] out_i;
  logic signed [W-1:0] out_q;

  // Upstream side: drives dibits, observes symbols.
  modport master (
    output in_valid, i_bit, q_bit,
    input  sym_valid, phase, out_i, out_q
  );

  // Encoder side.
  modport slave (
    input  in_valid, i_bit, q_bit,
    output sym_valid, phase, out_i, out_q
  );
endinterface

// File: rtl/dqpsk_diff_encoder.sv
// Differential QPSK encoder: samples one dibit per symbol period, Gray-maps it
// to a phase step, accumulates phase mod 4 and emits a registered I/Q point.
module dqpsk_diff_encoder #(
  parameter int SYM_CYCLES = 2,
  parameter int W          = 8,
  parameter int AMP        = 90
) (
  input  logic                 clk,
  input  logic                 rst,
  dqpsk_diff_encoder_if.slave  bus
);

  localparam int CW = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam logic [CW-1:0]         CNT_MAX   = CW'(SYM_CYCLES - 1);
  localparam logic [CW-1:0]         CNT_START = (SYM_CYCLES == 1) ? CW'(0) : CW'(1);
  localparam logic signed [W-1:0]   POS       = W'(AMP);
  localparam logic signed [W-1:0]   NEG       = W'(-AMP);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [1:0]          acc, acc_nx, inc;
  logic                sample;
  logic                sym_valid_q;
  logic signed [W-1:0] out_i_q, out_q_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sample   = 1'b0;
    unique case (state)
      IDLE: begin
        // First valid cycle after idle always samples, realigning the symbol grid.
        if (bus.in_valid) begin
          sample   = 1'b1;
          state_nx = RUN;
          cnt_nx   = CNT_START;
        end
      end
      RUN: begin
        if (!bus.in_valid) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          sample = (cnt == '0);
          cnt_nx = (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Gray-coded phase step: adjacent increments differ in one bit.
  always_comb begin
    unique case ({bus.i_bit, bus.q_bit})
      2'b00: inc = 2'd0;
      2'b01: inc = 2'd1;
      2'b11: inc = 2'd2;
      2'b10: inc = 2'd3;
    endcase
    acc_nx = acc + inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= 2'd0;
      sym_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      sym_valid_q <= sample;
      if (sample) begin
        acc <= acc_nx;
        unique case (acc_nx)
          2'd0: begin out_i_q <= POS; out_q_q <= POS; end
          2'd1: begin out_i_q <= NEG; out_q_q <= POS; end
          2'd2: begin out_i_q <= NEG; out_q_q <= NEG; end
          2'd3: begin out_i_q <= POS; out_q_q <= NEG; end
        endcase
      end
    end
  end

  assign bus.sym_valid = sym_valid_q;
  assign bus.phase     = acc;
  assign bus.out_i     = out_i_q;
  assign bus.out_q     = out_q_q;

endmodule
